// File: rtl/iob_skid_ctrl.sv
// Occupancy FSM for the 2-entry skid buffer: tracks EMPTY/BUSY/FULL and
// steers the main/skid data register loads in the top level.
module iob_skid_ctrl (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       cke,
  input  logic       clr,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic [1:0] state,
  output logic       main_en,
  output logic       main_sel,
  output logic       skid_en
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_nx;
  logic   in_xfer, out_xfer;

  // Handshakes use registered state only, so out_ready never reaches the ready decode.
  assign in_xfer  = in_valid & (state_q != FULL);
  assign out_xfer = out_ready & (state_q != EMPTY);
  assign state    = state_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= EMPTY;
    end else if (cke) begin
      if (clr) state_q <= EMPTY;
      else     state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    main_en  = 1'b0;
    main_sel = 1'b0;
    skid_en  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_nx = BUSY;
          main_en  = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          state_nx = FULL;
          skid_en  = 1'b1;
        end else if (out_xfer) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nx = BUSY;
          main_en  = 1'b1;
          main_sel = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

endmodule

// File: rtl/iob_reg_skid.sv
// Elastic valid/ready pipeline register (2-entry skid buffer) with synchronous
// clear and clock enable; both directions are fully registered.
module iob_reg_skid #(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  output logic              o_valid_o,
  output logic [DATA_W-1:0] o_data_o,
  input  logic              o_ready_i
);

  logic [1:0]        ctrl_state;
  logic              main_en, main_sel, skid_en;
  logic [DATA_W-1:0] main_q, skid_q;

  // valid/ready: a word moves on a rising edge with cke_i=1 when both valid and
  // ready are high; rst_i overrides, and ready/valid read 0 while cke_i=0.
  iob_skid_ctrl u_ctrl (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .cke      (cke_i),
    .clr      (rst_i),
    .in_valid (i_valid_i),
    .out_ready(o_ready_i),
    .state    (ctrl_state),
    .main_en  (main_en),
    .main_sel (main_sel),
    .skid_en  (skid_en)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        main_q <= RST_VAL;
        skid_q <= RST_VAL;
      end else begin
        if (main_en) main_q <= main_sel ? skid_q : i_data_i;
        if (skid_en) skid_q <= i_data_i;
      end
    end
  end

  assign i_ready_o = cke_i & (ctrl_state != 2'd2);
  assign o_valid_o = cke_i & (ctrl_state != 2'd0);
  assign o_data_o  = main_q;

endmodule
